mcycle_mem_responder: RTL and testbench

//  Memory-side responder for the multicycle core's load/store/fetch requests.
//  The core controller issues one request while a stage is enabled. This block

---
 rtl/mcycle_mem_responder_if.sv | 24 ++
 rtl/mcycle_mem_responder.sv | 113 +++++++++++
 tb/tb_mcycle_mem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_mem_responder_if.sv
// Request/response bus between the multicycle core and its memory responder.
interface mcycle_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  // Core side: issues requests, receives completions.
  modport master (
    output req_valid, req_write, req_addr, req_strobe, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  // Memory side: accepts requests, produces completions.
  modport slave (
    input  req_valid, req_write, req_addr, req_strobe, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mcycle_mem_responder.sv
// Fixed-latency word-addressed RAM responder for the multicycle core.
// One request is captured in IDLE, held through WAIT, and completed in a
// single RESP cycle where the store commits or the load is read.
module mcycle_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  mcycle_mem_responder_if.slave bus
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [31:0]         addr_q, addr_d;
  logic [3:0]          strobe_q, strobe_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         ram [Depth];
  logic [ADDR_W-1:0]   idx;
  logic                err_mis, err_oor, err;
  logic                in_resp, commit;

  // Address checks always use the captured address, never the live bus.
  assign idx     = addr_q[ADDR_W+1:2];
  assign err_mis = addr_q[1:0] != 2'b00;
  assign err_oor = addr_q[31:ADDR_W+2] != '0;
  assign err     = err_mis | err_oor;
  assign in_resp = state_q == StResp;
  assign commit  = in_resp & write_q & ~err;

  // State and captured-request registers; reset drops any pending request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          addr_d   = bus.req_addr;
          strobe_d = bus.req_strobe;
          wdata_d  = bus.req_wdata;
          cnt_d    = CntInit;
          state_d  = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: data and error are forced to zero outside the RESP pulse.
  always_comb begin
    bus.req_ready  = state_q == StIdle;
    bus.resp_valid = in_resp;
    bus.resp_err   = in_resp & err;
    bus.resp_data  = '0;
    if (in_resp && !write_q && !err) begin
      bus.resp_data = ram[idx];
    end
  end

  // Byte-enabled store commit; RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe_q[i]) begin
          ram[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mcycle_mem_responder.sv
// Randomized bench for mcycle_mem_responder: one instance at latency 2 and one
// at latency 1 share a driver; a word-array model predicts every response.
module tb_mcycle_mem_responder;

  localparam int unsigned AddrW = 10;
  localparam int unsigned Depth = 1 << AddrW;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        sel    = 1'b0;  // 0: latency-2 instance, 1: latency-1 instance

  logic        drv_valid  = 1'b0;
  logic        drv_write  = 1'b0;
  logic [31:0] drv_addr   = '0;
  logic [3:0]  drv_strobe = '0;
  logic [31:0] drv_wdata  = '0;

  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_data;

  logic [31:0] model [2][Depth];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mcycle_mem_responder_if bus_a ();
  mcycle_mem_responder_if bus_b ();

  assign bus_a.req_valid  = drv_valid && !sel;
  assign bus_b.req_valid  = drv_valid && sel;
  assign bus_a.req_write  = drv_write;
  assign bus_b.req_write  = drv_write;
  assign bus_a.req_addr   = drv_addr;
  assign bus_b.req_addr   = drv_addr;
  assign bus_a.req_strobe = drv_strobe;
  assign bus_b.req_strobe = drv_strobe;
  assign bus_a.req_wdata  = drv_wdata;
  assign bus_b.req_wdata  = drv_wdata;

  assign obs_ready = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign obs_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign obs_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
  assign obs_data  = sel ? bus_b.resp_data  : bus_a.resp_data;

  mcycle_mem_responder #(.ADDR_W(AddrW), .LATENCY(2)) u_dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  mcycle_mem_responder #(.ADDR_W(AddrW), .LATENCY(1)) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * Depth));
  endfunction

  function automatic int word_of(input int r);
    return (r < 16) ? r : int'(Depth) - 4 + (r - 16);
  endfunction

  function automatic logic [31:0] rand_addr();
    int w = word_of(int'($urandom_range(19)));
    int k = int'($urandom_range(9));
    if (k == 8) return 32'(w * 4) + 32'($urandom_range(1, 3));
    if (k == 9) return ($urandom_range(1) == 1) ? 32'(4 * Depth) : ($urandom | 32'h1000);
    return 32'(w * 4);
  endfunction

  // One request on the selected instance; optionally pulses a stray store in WAIT.
  task automatic do_req(input bit write, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit stray);
    int          lat = sel ? 1 : 2;
    int          cyc = 0;
    int          idx;
    bit          err;
    logic [31:0] exp_data;
    @(negedge clk);
    chk("idle_ready", 32'(obs_ready), 32'd1);
    chk("idle_valid", 32'(obs_valid), 32'd0);
    chk("idle_data", obs_data, 32'd0);
    drv_valid  = 1'b1;
    drv_write  = write;
    drv_addr   = a;
    drv_strobe = s;
    drv_wdata  = d;
    @(posedge clk);
    #1;
    if (stray) begin
      drv_write  = 1'b1;
      drv_addr   = (a[31:2] == 30'd5) ? 32'h18 : 32'h14;
      drv_strobe = 4'hF;
      drv_wdata  = ~d;
    end else begin
      drv_valid = 1'b0;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cyc = i;
      chk("busy_ready", 32'(obs_ready), 32'd0);
      if (obs_valid) break;
      if (stray && i == 1) begin
        @(posedge clk);
        #1 drv_valid = 1'b0;
      end
    end
    drv_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    err = addr_err(a);
    idx = int'(a[AddrW+1:2]);
    if (write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[sel][idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    exp_data = (!write && !err) ? model[sel][idx] : 32'd0;
    chk("resp_err", 32'(obs_err), 32'(err));
    chk("resp_data", obs_data, exp_data);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_ready_a", 32'(bus_a.req_ready), 32'd1);
    chk("rst_valid_a", 32'(bus_a.resp_valid), 32'd0);
    chk("rst_data_a", bus_a.resp_data, 32'd0);
    chk("rst_err_a", 32'(bus_a.resp_err), 32'd0);
    chk("rst_ready_b", 32'(bus_b.req_ready), 32'd1);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Give every word the bench will read a known value in both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int r = 0; r < 20; r++) do_req(1'b1, 32'(word_of(r) * 4), 4'hF, $urandom, 1'b0);
    end
    sel = 1'b0;

    // Full-word store then load.
    do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    chk("t1_load", obs_data, 32'hDEADBEEF);

    // Partial byte strobes merge into the existing word.
    do_req(1'b1, 32'h18, 4'hF, 32'h11223344, 1'b0);
    do_req(1'b1, 32'h18, 4'b0101, 32'hAABBCCDD, 1'b0);
    do_req(1'b0, 32'h18, 4'h0, 32'h0, 1'b0);
    chk("t2_merge", obs_data, 32'h11BB33DD);

    // Misaligned load and store one word past the top both error out.
    do_req(1'b0, 32'h13, 4'h0, 32'h0, 1'b0);
    chk("t3_mis_err", 32'(obs_err), 32'd1);
    do_req(1'b1, 32'(4 * Depth), 4'hF, 32'h55555555, 1'b0);
    chk("t3_oor_err", 32'(obs_err), 32'd1);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 32'h14, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 32'(4 * (Depth - 1)), 4'h0, 32'h0, 1'b0);
    chk("t3_top_ok", 32'(obs_err), 32'd0);

    // Stray store pulsed during WAIT must be ignored.
    do_req(1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'h14, 4'h0, 32'h0, 1'b0);

    // Reset during WAIT of a store drops it.
    @(negedge clk);
    drv_valid  = 1'b1;
    drv_write  = 1'b1;
    drv_addr   = 32'h20;
    drv_strobe = 4'hF;
    drv_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    resetn    = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(obs_valid), 32'd0);
    chk("t5_rst_ready", 32'(obs_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(obs_valid), 32'd0);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    do_req(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);

    // Randomized traffic on the latency-2 instance.
    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom_range(1)), rand_addr(), 4'($urandom), $urandom,
             $urandom_range(9) == 0);
    end

    // Latency 1: back-to-back loads.
    sel = 1'b1;
    do_req(1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
    do_req(1'b1, 32'h4, 4'hF, 32'h12345678, 1'b0);
    do_req(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("t6_load0", obs_data, 32'h0BADF00D);
    do_req(1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    chk("t6_load4", obs_data, 32'h12345678);
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom_range(1)), rand_addr(), 4'($urandom), $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
